// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes and FSM states.
// No logic, no latency.
// Imported by the ALU, the arbiter and the bench.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and one consumer.
// Pure wiring, no latency.
// Valid/ready on both the request and the response side.
interface alu_arbiter_if #(parameter int N = 4);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][N-1:0] req_op1;
  logic [1:0][N-1:0] req_op2;
  logic [1:0][1:0]   req_opcode;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N:0]        rsp_result;
  logic              rsp_id;
  logic              busy;
  logic [7:0]        op_count;

  // Requesters plus response consumer
  modport master (
    output req_valid, req_op1, req_op2, req_opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id, busy, op_count
  );

  // Arbiter
  modport slave (
    input  req_valid, req_op1, req_op2, req_opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id, busy, op_count
  );

endinterface

// File: rtl/alu.sv
// Combinational N-bit ALU with an (N+1)-bit result: add, sub, and, or.
// Zero latency.
// No flow control; the caller registers the result.
module alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] i_op1,
  input  logic [N-1:0] i_op2,
  input  opcode_t      i_opcode,
  output logic [N:0]   o_result
);

  // Sub wraps modulo 2^(N+1); logic ops leave the top bit at zero
  always_comb begin
    o_result = '0;
    case (i_opcode)
      ADD:     o_result = {1'b0, i_op1} + {1'b0, i_op2};
      SUB:     o_result = {1'b0, i_op1} - {1'b0, i_op2};
      AND:     o_result = {1'b0, i_op1 & i_op2};
      OR:      o_result = {1'b0, i_op1 | i_op2};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting one of two requesters a shared ALU, result held until consumed.
// Grant combinational in IDLE; result valid one edge after acceptance; one op per three cycles max.
// Requests are refused while an operation is in flight; the response holds until rsp_ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  state_t       r_state;
  state_t       w_next_state;
  logic [1:0]   w_req_ready;
  logic         w_grant_id;
  logic         w_accept;
  logic         w_rsp_hs;
  logic         r_last_grant;
  logic         r_id;
  logic [N-1:0] r_op1;
  logic [N-1:0] r_op2;
  opcode_t      r_opcode;
  logic         r_rsp_valid;
  logic [N:0]   r_rsp_result;
  logic         r_rsp_id;
  logic [7:0]   r_op_count;
  logic [N:0]   w_alu_result;

  // A lone requester wins; on a tie the one not served last time wins
  assign w_grant_id = (bus.req_valid == 2'b11) ? ~r_last_grant : bus.req_valid[1];
  assign w_accept   = |w_req_ready;
  assign w_rsp_hs   = r_rsp_valid & bus.rsp_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next state and grant; req_ready is forced low while reset is held
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 2'b00;
    case (r_state)
      IDLE: begin
        if (|bus.req_valid && !rst) begin
          w_req_ready  = w_grant_id ? 2'b10 : 2'b01;
          w_next_state = EXEC;
        end
      end
      EXEC:    w_next_state = DONE;
      DONE:    if (bus.rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture on accept, result capture out of EXEC, count on response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_opcode     <= ADD;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= 1'b0;
      r_op_count   <= 8'd0;
    end else begin
      if (w_accept) begin
        r_op1        <= bus.req_op1[w_grant_id];
        r_op2        <= bus.req_op2[w_grant_id];
        r_opcode     <= opcode_t'(bus.req_opcode[w_grant_id]);
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == EXEC) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= w_alu_result;
        r_rsp_id     <= r_id;
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= r_op_count + 8'd1;
      end
    end
  end

  alu #(.N(N)) u_alu (
    .i_op1    (r_op1),
    .i_op2    (r_op2),
    .i_opcode (r_opcode),
    .o_result (w_alu_result)
  );

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.busy       = (r_state != IDLE);
  assign bus.op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed operations with literal expectations plus a
// cycle-by-cycle transaction-level model checked on every falling edge.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 4;
  localparam int M = 1 << (N + 1);

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_arbiter_if #(.N(N)) bus ();

  alu_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference result from the arithmetic definitions, using plain integers
  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % M;
      1:       return ((a - b) % M + M) % M;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  // Model: at most one operation in flight; response visible from one edge after acceptance
  bit         m_busy;
  int         m_age;
  int         m_res;
  int         m_id;
  int         m_last;
  int         m_cnt;

  always @(negedge clk) begin
    logic [1:0] e_rdy;
    int         w;
    e_rdy = 2'b00;
    w     = 0;
    if (rst) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_result", bus.rsp_result, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_op_count", bus.op_count, 0);
      m_busy = 0;
      m_age  = 0;
      m_last = 1;
      m_cnt  = 0;
    end else begin
      if (!m_busy && bus.req_valid != 2'b00) begin
        if (bus.req_valid == 2'b11) w = 1 - m_last;
        else                        w = bus.req_valid[0] ? 0 : 1;
        e_rdy[w] = 1'b1;
      end
      chk("m_req_ready", bus.req_ready, e_rdy);
      chk("m_busy", bus.busy, m_busy);
      chk("m_rsp_valid", bus.rsp_valid, (m_busy && m_age >= 1));
      if (m_busy && m_age >= 1) begin
        chk("m_rsp_result", bus.rsp_result, m_res);
        chk("m_rsp_id", bus.rsp_id, m_id);
      end
      chk("m_op_count", bus.op_count, m_cnt);
      if (m_busy) begin
        if (m_age >= 1 && bus.rsp_ready) begin
          m_busy = 0;
          m_cnt  = (m_cnt + 1) % 256;
        end else begin
          m_age++;
        end
      end else if (bus.req_valid != 2'b00) begin
        m_busy = 1;
        m_age  = 0;
        m_res  = ref_alu(int'(bus.req_op1[w]), int'(bus.req_op2[w]), int'(bus.req_opcode[w]));
        m_id   = w;
        m_last = w;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left 1 unit after a rising edge, with the DUT idle
  task automatic run_op(input logic [1:0] v,
                        input int a0, input int b0, input int o0,
                        input int a1, input int b1, input int o1,
                        input logic [1:0] exp_gnt, input int exp_res, input int exp_id,
                        input int hold, input int exp_cnt);
    bus.req_valid     = v;
    bus.req_op1[0]    = a0[N-1:0];
    bus.req_op2[0]    = b0[N-1:0];
    bus.req_opcode[0] = o0[1:0];
    bus.req_op1[1]    = a1[N-1:0];
    bus.req_op2[1]    = b1[N-1:0];
    bus.req_opcode[1] = o1[1:0];
    @(negedge clk);
    chk("grant", bus.req_ready, exp_gnt);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("exec_rsp_valid", bus.rsp_valid, 0);
    chk("exec_busy", bus.busy, 1);
    tick();
    @(negedge clk);
    chk("done_rsp_valid", bus.rsp_valid, 1);
    chk("done_rsp_result", bus.rsp_result, exp_res);
    chk("done_rsp_id", bus.rsp_id, exp_id);
    for (int i = 0; i < hold; i++) begin
      tick();
      bus.req_valid = 2'b11;
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_result", bus.rsp_result, exp_res);
      chk("hold_rsp_id", bus.rsp_id, exp_id);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("after_busy", bus.busy, 0);
    chk("after_op_count", bus.op_count, exp_cnt);
    tick();
  endtask

  initial begin
    int n;
    int cycles;
    total = 0;
    bad   = 0;
    rst               = 1'b1;
    bus.req_valid     = 2'b11;
    bus.req_op1       = '0;
    bus.req_op2       = '0;
    bus.req_opcode    = '0;
    bus.rsp_ready     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_busy", bus.busy, 0);
    tick();
    rst           = 1'b0;
    bus.req_valid = 2'b00;
    tick();

    // Ties alternate starting with requester 0, then single requesters and opcodes
    run_op(2'b11, 7, 9, 0, 3, 5, 1, 2'b01, 16, 0, 0, 1);
    run_op(2'b11, 7, 9, 0, 3, 5, 1, 2'b10, 30, 1, 0, 2);
    run_op(2'b11, 15, 15, 0, 3, 5, 1, 2'b01, 30, 0, 0, 3);
    run_op(2'b01, 7, 9, 0, 0, 0, 0, 2'b01, 16, 0, 0, 4);
    run_op(2'b10, 0, 0, 0, 12, 10, 2, 2'b10, 8, 1, 5, 5);
    run_op(2'b10, 0, 0, 0, 12, 10, 3, 2'b10, 14, 1, 0, 6);
    run_op(2'b01, 0, 1, 1, 0, 0, 0, 2'b01, 31, 0, 0, 7);

    // Reset in EXEC drops the operation and clears everything at once
    bus.req_valid  = 2'b01;
    bus.req_op1[0] = 4'd5;
    bus.req_op2[0] = 4'd6;
    bus.req_opcode[0] = 2'b00;
    tick();
    bus.req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("rstexec_busy", bus.busy, 0);
    chk("rstexec_rsp_valid", bus.rsp_valid, 0);
    chk("rstexec_rsp_result", bus.rsp_result, 0);
    chk("rstexec_op_count", bus.op_count, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstexec_no_rsp", bus.rsp_valid, 0);
      tick();
    end

    // 256 back-to-back operations wrap the counter, one per three cycles
    n      = 0;
    cycles = 0;
    bus.rsp_ready     = 1'b1;
    bus.req_valid     = 2'b01;
    bus.req_opcode[0] = 2'b00;
    bus.req_op2[0]    = 4'd9;
    while (n < 256 && cycles < 2000) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) n++;
      tick();
      cycles++;
      bus.req_op1[0] = cycles[N-1:0];
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("wrap_ops_done", n, 256);
    chk("wrap_op_count", bus.op_count, 0);
    chk("wrap_cycles", cycles, 768);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 4, operand width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept strobe; at most one bit high.
REQ-006 req_op1  input  2xN (packed [1:0][N-1:0])  first operand per requester.
REQ-007 req_op2  input  2xN  second operand per requester.
REQ-008 req_opcode  input  2x2  operation per requester: 00 add, 01 sub, 10 and, 11 or.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_result  output  N+1  ALU result.
REQ-012 rsp_id  output  1  index of the requester that owns rsp_result.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 op_count  output  8  count of completed response handshakes.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-016 In IDLE, if any req_valid bit is high, the arbiter SHALL assert req_ready for exactly one requester, combinationally in that cycle.
REQ-017 A single requesting requester SHALL win. When both request, the winner SHALL be the requester not equal to last_grant (round-robin).
REQ-018 On the edge where req_valid[g] and req_ready[g] are both high, the block SHALL latch op1, op2, opcode and g, update last_grant to g, and go to EXEC.
REQ-019 In EXEC, the latched operands SHALL drive the ALU. On the next edge, the block SHALL register the result into rsp_result, register g into rsp_id, set rsp_valid to 1, and go to DONE.
REQ-020 Latency: for a request accepted on edge k, rsp_valid SHALL be high from edge k+1.
REQ-021 In DONE, rsp_valid, rsp_result and rsp_id SHALL hold stable until rsp_valid and rsp_ready are both high. On that edge, rsp_valid SHALL clear, op_count SHALL increment, and the state SHALL return to IDLE.
REQ-022 req_ready SHALL be 0 in EXEC and DONE. Requests arriving in those states, including one in the same cycle as a response handshake, SHALL be accepted no earlier than the next IDLE cycle.
REQ-023 Add: result SHALL be the (N+1)-bit sum, with the carry in bit N.
REQ-024 Sub: result SHALL be op1-op2 modulo 2^(N+1). Example for N=4: 3-5 = 5'b11110.
REQ-025 And/or: result SHALL be the bitwise result, zero-extended, with bit N = 0.
REQ-026 op_count SHALL wrap from 255 to 0.
REQ-027 Maximum throughput SHALL be one operation per three cycles when rsp_ready is held high.

Reset
REQ-028 While rst is high, the state SHALL be IDLE and req_ready, rsp_valid, rsp_result, rsp_id, busy and op_count SHALL all be 0.
REQ-029 After reset, last_grant SHALL be 1, so that requester 0 wins the first tie.
REQ-030 Reset asserted in EXEC or DONE SHALL discard the in-flight operation without producing a response.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode enum (ADD=2'b00, SUB=2'b01, AND=2'b10, OR=2'b11) and the state enum (IDLE, EXEC, DONE).
REQ-032 The arithmetic SHALL come from one instance of the existing alu module, with parameter N passed through. alu_arbiter SHALL contain no arithmetic of its own.

Verification
REQ-033 Requester 0 only: op1=7, op2=9, opcode=00 -> req_ready=2'b01 in the request cycle; after one cycle, rsp_valid=1, rsp_result=5'd16, rsp_id=0.
REQ-034 Both requesters valid in IDLE after reset -> requester 0 is granted first; after its response handshake, requester 1 is granted; next tie -> requester 0 is granted.
REQ-035 Requester 1: op1=3, op2=5, opcode=01 -> rsp_result=5'b11110. Requester 1: op1=4'hC, op2=4'hA, opcode=10 -> rsp_result=5'h08; opcode=11 -> rsp_result=5'h0E.
REQ-036 rsp_ready held low for 5 cycles in DONE -> rsp_valid, rsp_result and rsp_id stay stable and req_ready stays 0; rsp_ready=1 -> state returns to IDLE and op_count increments by 1.
REQ-037 rst pulsed during EXEC -> all outputs become 0 immediately, no response is produced, and op_count stays 0.
REQ-038 256 back-to-back completed operations -> op_count returns to 0.
